// File: rtl/core_pkg.sv
// Shared opcode/state types and instruction field layout for the core sequencer.
// Optional single-step support is enabled by defining CORE_SEQ_STEP_EN.
package core_pkg;

    typedef enum logic [3:0] {
        OP_CP          = 4'd0,
        OP_ADD         = 4'd1,
        OP_SUB         = 4'd2,
        OP_NOT         = 4'd3,
        OP_AND         = 4'd4,
        OP_OR          = 4'd5,
        OP_XOR         = 4'd6,
        OP_RSH         = 4'd7,
        OP_LSH         = 4'd8,
        OP_CMP_GREATER = 4'd9,
        OP_CMP_EQUAL   = 4'd10,
        OP_CMP_LESS    = 4'd11,
        OP_OUT_T       = 4'd12,
        OP_OUT_F       = 4'd13,
        OP_ILLEGAL     = 4'd14,
        OP_HALT        = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_PAUSE
    } state_e;

    localparam int INSTR_W     = 32;
    localparam int OP_LSB      = 0;
    localparam int OP_W        = 4;
    localparam int RD_LSB      = 4;
    localparam int RA_LSB      = 8;
    localparam int RB_LSB      = 12;
    localparam int REG_IDX_W   = 4;
    localparam int IMM_SEL_BIT = 16;
    localparam int IMM_LSB     = 20;
    localparam int IMM_W       = 12;

    typedef struct packed {
        opcode_e                op;
        logic [REG_IDX_W-1:0]   rd;
        logic [REG_IDX_W-1:0]   ra;
        logic [REG_IDX_W-1:0]   rb;
        logic                   imm_sel;
        logic [IMM_W-1:0]       imm;
    } instr_t;

    // Ops below the branch pair write their ALU result to rd; branches write PC.
    function automatic logic writes_reg(input opcode_e op);
        return op <= OP_CMP_LESS;
    endfunction

endpackage

// File: rtl/core_seq_reg_file.sv
// Register file: REGS x DW storage, two combinational read ports, one synchronous
// write port. Register 0 always reads zero and ignores writes.
module reg_file
    import core_pkg::*;
#(
    parameter int DW   = 32,
    parameter int REGS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [DW-1:0]        wdata_i,
    input  logic [REG_IDX_W-1:0] raddr_a_i,
    input  logic [REG_IDX_W-1:0] raddr_b_i,
    output logic [DW-1:0]        rdata_a_o,
    output logic [DW-1:0]        rdata_b_o
);

    logic [DW-1:0] regs_q [REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/core_seq.sv
// Instruction sequencer around an external combinational ALU: fetch, decode, execute,
// one instruction in flight. Define CORE_SEQ_STEP_EN to add the step input and PAUSE state.
module core_seq
    import core_pkg::*;
#(
    parameter int bit_width = 32,
    parameter int ADDR_W    = 8,
    parameter int REGS      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
`ifdef CORE_SEQ_STEP_EN
    input  logic                 step,
`endif
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [3:0]           alu_op,
    output logic [bit_width-1:0] alu_a,
    output logic [bit_width-1:0] alu_b,
    output logic [bit_width-1:0] alu_pc,
    input  logic [bit_width-1:0] alu_r,
    output logic                 halted,
    output logic                 illegal,
    output logic [bit_width-1:0] pc
);

    state_e               state_q, state_d;
    instr_t               instr_q, instr_d;
    logic [bit_width-1:0] pc_q, pc_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [bit_width-1:0] alu_a_q, alu_a_d;
    logic [bit_width-1:0] alu_b_q, alu_b_d;
    logic [bit_width-1:0] alu_pc_q, alu_pc_d;
    logic                 halted_q, halted_d;
    logic                 illegal_q, illegal_d;
    logic                 reg_we;
    logic [bit_width-1:0] ra_data, rb_data;
    logic                 unused_instr_bits;

`ifdef CORE_SEQ_STEP_EN
    logic                 step_armed_q, step_armed_d;
`endif

    assign unused_instr_bits = ^imem_data[IMM_LSB-1:IMM_SEL_BIT+1];

    reg_file #(
        .DW   (bit_width),
        .REGS (REGS)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .we_i      (reg_we),
        .waddr_i   (instr_q.rd),
        .wdata_i   (alu_r),
        .raddr_a_i (instr_q.ra),
        .raddr_b_i (instr_q.rb),
        .rdata_a_o (ra_data),
        .rdata_b_o (rb_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_pc_q  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_pc_q  <= alu_pc_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CORE_SEQ_STEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_armed_q <= 1'b1;
        end else begin
            step_armed_q <= step_armed_d;
        end
    end
`endif

    // Operands are read in DECODE from the pre-write register state, so rd==ra sees the old value.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        alu_op_d  = alu_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_pc_d  = alu_pc_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        reg_we    = 1'b0;
`ifdef CORE_SEQ_STEP_EN
        step_armed_d = step_armed_q;
        if (!step) begin
            step_armed_d = 1'b1;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d.op      = opcode_e'(imem_data[OP_LSB +: OP_W]);
                    instr_d.rd      = imem_data[RD_LSB +: REG_IDX_W];
                    instr_d.ra      = imem_data[RA_LSB +: REG_IDX_W];
                    instr_d.rb      = imem_data[RB_LSB +: REG_IDX_W];
                    instr_d.imm_sel = imem_data[IMM_SEL_BIT];
                    instr_d.imm     = imem_data[IMM_LSB +: IMM_W];
                    state_d         = ST_DECODE;
                end
            end

            ST_DECODE: begin
                alu_op_d = instr_q.op;
                alu_a_d  = ra_data;
                alu_b_d  = instr_q.imm_sel ? {{(bit_width-IMM_W){1'b0}}, instr_q.imm} : rb_data;
                alu_pc_d = pc_q;
                if (instr_q.op == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (instr_q.op == OP_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (writes_reg(instr_q.op)) begin
                    reg_we = 1'b1;
                    pc_d   = pc_q + bit_width'(1);
                end else begin
                    pc_d = alu_r;
                end
`ifdef CORE_SEQ_STEP_EN
                state_d = ST_PAUSE;
`else
                state_d = run ? ST_FETCH : ST_IDLE;
`endif
            end

`ifdef CORE_SEQ_STEP_EN
            // A held step only advances once; it must return low before it counts again.
            ST_PAUSE: begin
                if (step && step_armed_q) begin
                    step_armed_d = 1'b0;
                    state_d      = run ? ST_FETCH : ST_IDLE;
                end
            end
`endif

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q[ADDR_W-1:0];
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_pc    = alu_pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign pc        = pc_q;

endmodule
